// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: PC register plus a four-state fetch FSM with a single outstanding
// memory request. Define PC_MISALIGN_TRAP_EN to reject misaligned redirects and flag them.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pcplus4,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        discard_q;
  logic        instr_valid_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        misalign_q;

  logic        redir_take;
  logic        misalign_hit;
  logic [31:0] redir_pc;

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_hit = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign redir_take   = redirect_valid && !misalign_hit;
  assign redir_pc     = redirect_target;
`else
  assign misalign_hit = 1'b0;
  assign redir_take   = redirect_valid;
  assign redir_pc     = redirect_target & 32'hFFFF_FFFC;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_VECTOR;
      discard_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      misalign_q    <= 1'b0;
    end else begin
      misalign_q <= misalign_hit;
      // Consumer took the instruction; a capture below on the same edge overrides this.
      if (instr_valid_q && !stall) begin
        instr_valid_q <= 1'b0;
      end
      if (misalign_hit) begin
        instr_valid_q <= 1'b0;
      end

      if (redir_take) begin
        pc_q          <= redir_pc;
        instr_valid_q <= 1'b0;
        case (state_q)
          S_REQ: begin
            if (imem_ready) begin
              // The old-address request is already issued; its response must be dropped.
              state_q   <= S_WAIT;
              discard_q <= 1'b1;
            end else begin
              state_q <= S_REQ;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              state_q   <= S_REQ;
              discard_q <= 1'b0;
            end else begin
              discard_q <= 1'b1;
            end
          end
          default: state_q <= S_REQ;
        endcase
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_REQ;
          S_REQ: begin
            if (imem_ready) begin
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (discard_q) begin
                discard_q <= 1'b0;
                state_q   <= S_REQ;
              end else begin
                instr_q       <= imem_rdata;
                instr_pc_q    <= pc_q;
                pc_q          <= pcplus4;
                instr_valid_q <= 1'b1;
                state_q       <= stall ? S_HOLD : S_REQ;
              end
            end
          end
          S_HOLD: begin
            if (!stall) begin
              state_q <= S_REQ;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign pc           = pc_q;
  assign imem_req     = (state_q == S_REQ);
  assign imem_addr    = pc_q;
  assign instr_valid  = instr_valid_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: scoreboard of expected (instr_pc, instr) pairs,
// memory responses driven step by step, immediate assertions at every check.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pcplus4;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  pc_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pcplus4         (pcplus4),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .pc              (pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  // Models the external PC+4 stage.
  assign pcplus4 = pc + 32'd4;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
  endtask

  task automatic clear_redirect();
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
  endtask

  // Issue one request from REQ at address a and return its data one cycle after accept.
  task automatic fetch(input logic [31:0] a, input logic st);
    logic [63:0] e;
    chk("req_hi", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, a);
    sb.push_back({a, dat(a)});
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    chk("wait_no_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = dat(a);
    stall       = st;
    cyc();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    chk("cap_valid", {31'd0, instr_valid}, 32'd1);
    e = sb.pop_front();
    chk("cap_instr_pc", instr_pc, e[63:32]);
    chk("cap_instr", instr, e[31:0]);
    $display("txn: instr_pc=%h instr=%h", instr_pc, instr);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    chk({tag, "_misalign"}, {31'd0, misalign_err}, 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    clear_redirect();

    // Reset state
    cyc();
    cyc();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    chk("idle_no_req", {31'd0, imem_req}, 32'd0);
    cyc();

    // Sequential fetch, then a 3-cycle stall after the capture at 0x4
    fetch(32'h0, 1'b0);
    fetch(32'h4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_pc", instr_pc, 32'h4);
      chk("hold_instr", instr, dat(32'h4));
      chk("hold_no_req", {31'd0, imem_req}, 32'd0);
      cyc();
    end
    stall = 1'b0;
    cyc();
    chk("unstall_valid", {31'd0, instr_valid}, 32'd0);
    chk("unstall_req", {31'd0, imem_req}, 32'd1);
    chk("unstall_addr", imem_addr, 32'h8);

    // Redirect while waiting for 0x8: the 0x8 response is dropped
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    redirect(32'h100);
    cyc();
    clear_redirect();
    chk("rw_pc", pc, 32'h100);
    chk("rw_no_req", {31'd0, imem_req}, 32'd0);
    chk("rw_valid", {31'd0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = dat(32'h8);
    cyc();
    imem_rvalid = 1'b0;
    chk("rw_drop_valid", {31'd0, instr_valid}, 32'd0);
    fetch(32'h100, 1'b0);

    // Redirect in the same cycle as the response
    imem_ready = 1'b1;
    cyc();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = dat(32'h104);
    redirect(32'h200);
    cyc();
    imem_rvalid = 1'b0;
    clear_redirect();
    chk("rv_valid", {31'd0, instr_valid}, 32'd0);
    fetch(32'h200, 1'b0);

    // Redirect in the same cycle as the accept: one response discarded
    imem_ready = 1'b1;
    redirect(32'h300);
    cyc();
    imem_ready = 1'b0;
    clear_redirect();
    chk("ra_no_req", {31'd0, imem_req}, 32'd0);
    chk("ra_pc", pc, 32'h300);
    imem_rvalid = 1'b1;
    imem_rdata  = dat(32'h204);
    cyc();
    imem_rvalid = 1'b0;
    chk("ra_drop_valid", {31'd0, instr_valid}, 32'd0);
    fetch(32'h300, 1'b0);

    // Misaligned redirect
    redirect(32'h102);
    cyc();
    clear_redirect();
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
    chk("mis_pc", pc, 32'h304);
    cyc();
    chk("mis_pulse_end", {31'd0, misalign_err}, 32'd0);
    fetch(32'h304, 1'b0);
`else
    chk("mis_none", {31'd0, misalign_err}, 32'd0);
    fetch(32'h100, 1'b0);
`endif

    // PC wraps modulo 2^32
    redirect(32'hFFFF_FFFC);
    cyc();
    clear_redirect();
    fetch(32'hFFFF_FFFC, 1'b0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Asynchronous reset in WAIT, then a late response after release is ignored
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    cyc();
    cyc();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    cyc();
    imem_rvalid = 1'b0;
    chk("late_valid", {31'd0, instr_valid}, 32'd0);
    fetch(32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
